// File: rtl/multi_pixel_frequency_manager.sv
// rtl/multi_pixel_frequency_manager.sv - per-pixel edge-period classifier with register dump
//
// Samples CHANNELS pixel positions from a line-scan stream, measures the period
// between rising edges of each sampled bit, accumulates periods falling into two
// frequency windows, and on stop dumps 2*CHANNELS accumulators over a register
// write port, then pulses irq.
//
// Ports:
//   s00_axi_aclk, s00_axi_aresetn : clock, asynchronous active-low reset
//   data, data_valid, line_start  : pixel stream (line_start marks pixel 0)
//   pixel_indexes                 : packed per-channel pixel index
//   threshold                     : sample threshold (FREQ_ANALYZER_THRESHOLD_EN only)
//   start, stop, clear            : control strobes
//   register_operation/number/write, register_ack : dump write port
//   busy, irq                     : dump in progress / dump complete pulse
//
// Optional feature macro: FREQ_ANALYZER_THRESHOLD_EN selects (data >= threshold)
// as the sampled bit instead of the data MSB.

module multi_pixel_frequency_manager #(
    parameter int CHANNELS            = 3,
    parameter int PIXEL_INDEX_WIDTH   = 10,
    parameter int DATA_WIDTH          = 8,
    parameter int COUNTER_WIDTH       = 32,
    parameter int CLOCK               = 100000000,
    parameter int FREQUENCY_1         = 9000,
    parameter int FREQUENCY_2         = 11000,
    parameter int FREQUENCY_DEVIATION = 10
) (
    input  logic                                  s00_axi_aclk,
    input  logic                                  s00_axi_aresetn,
    input  logic [DATA_WIDTH-1:0]                 data,
    input  logic                                  data_valid,
    input  logic                                  line_start,
    input  logic [CHANNELS*PIXEL_INDEX_WIDTH-1:0] pixel_indexes,
    input  logic [DATA_WIDTH-1:0]                 threshold,
    input  logic                                  start,
    input  logic                                  stop,
    input  logic                                  clear,
    output logic [1:0]                            register_operation,
    output logic [7:0]                            register_number,
    output logic [31:0]                           register_write,
    input  logic                                  register_ack,
    output logic                                  busy,
    output logic                                  irq
);

    localparam int P1     = CLOCK / FREQUENCY_1;
    localparam int P2     = CLOCK / FREQUENCY_2;
    localparam int P1_MIN = P1 - P1 * FREQUENCY_DEVIATION / 100;
    localparam int P1_MAX = P1 + P1 * FREQUENCY_DEVIATION / 100;
    localparam int P2_MIN = P2 - P2 * FREQUENCY_DEVIATION / 100;
    localparam int P2_MAX = P2 + P2 * FREQUENCY_DEVIATION / 100;

    localparam logic [COUNTER_WIDTH-1:0] P1_MIN_C = COUNTER_WIDTH'(P1_MIN);
    localparam logic [COUNTER_WIDTH-1:0] P1_MAX_C = COUNTER_WIDTH'(P1_MAX);
    localparam logic [COUNTER_WIDTH-1:0] P2_MIN_C = COUNTER_WIDTH'(P2_MIN);
    localparam logic [COUNTER_WIDTH-1:0] P2_MAX_C = COUNTER_WIDTH'(P2_MAX);

    // Dump index is {channel, odd}: odd selects f2, even selects f1.
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [CH_W:0] LAST_REG = (CH_W + 1)'(2 * CHANNELS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DUMP,
        S_DONE
    } state_t;

    state_t state, state_next;
    logic [CH_W:0] dump_idx, dump_idx_next;
    logic [CH_W-1:0] ch_sel;

    logic [PIXEL_INDEX_WIDTH-1:0] pixel_count;
    logic [PIXEL_INDEX_WIDTH-1:0] current_index;
    logic [CHANNELS-1:0]          sample;
    logic [CHANNELS-1:0]          sample_prev;
    logic [CHANNELS-1:0]          armed;
    logic [COUNTER_WIDTH-1:0]     period [CHANNELS];
    logic [COUNTER_WIDTH-1:0]     f1     [CHANNELS];
    logic [COUNTER_WIDTH-1:0]     f2     [CHANNELS];

    logic pixel_bit;
    logic run_active;
    logic clear_active;

`ifdef FREQ_ANALYZER_THRESHOLD_EN
    assign pixel_bit = (data >= threshold);
`else
    logic unused_threshold;
    assign unused_threshold = ^threshold;
    assign pixel_bit        = data[DATA_WIDTH-1];
`endif

    assign run_active    = (state == S_RUN);
    assign clear_active  = clear && ((state == S_IDLE) || (state == S_RUN));
    assign current_index = line_start ? '0 : pixel_count;

    function automatic logic [COUNTER_WIDTH-1:0] sat_add(
        input logic [COUNTER_WIDTH-1:0] a,
        input logic [COUNTER_WIDTH-1:0] b
    );
        logic [COUNTER_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[COUNTER_WIDTH] ? '1 : s[COUNTER_WIDTH-1:0];
    endfunction

    // Pixel counter and per-channel sample capture.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            pixel_count <= '0;
            sample      <= '0;
        end else if (clear_active) begin
            pixel_count <= '0;
            sample      <= '0;
        end else if (run_active && data_valid) begin
            // line_start marks the current pixel as index 0, so the next is 1.
            pixel_count <= line_start ? PIXEL_INDEX_WIDTH'(1)
                                      : pixel_count + PIXEL_INDEX_WIDTH'(1);
            for (int c = 0; c < CHANNELS; c++) begin
                if (current_index == pixel_indexes[c*PIXEL_INDEX_WIDTH +: PIXEL_INDEX_WIDTH])
                    sample[c] <= pixel_bit;
            end
        end
    end

    // Edge detection, period measurement and window accumulation.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            sample_prev <= '0;
            armed       <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                period[c] <= '0;
                f1[c]     <= '0;
                f2[c]     <= '0;
            end
        end else if (clear_active) begin
            sample_prev <= '0;
            armed       <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                period[c] <= '0;
                f1[c]     <= '0;
                f2[c]     <= '0;
            end
        end else if (run_active) begin
            sample_prev <= sample;
            for (int c = 0; c < CHANNELS; c++) begin
                if (sample[c] && !sample_prev[c]) begin
                    period[c] <= COUNTER_WIDTH'(1);
                    // The first edge has no reference point, so it only arms.
                    if (!armed[c]) begin
                        armed[c] <= 1'b1;
                    end else if (period[c] >= P1_MIN_C && period[c] <= P1_MAX_C) begin
                        f1[c] <= sat_add(f1[c], period[c]);
                    end else if (period[c] >= P2_MIN_C && period[c] <= P2_MAX_C) begin
                        f2[c] <= sat_add(f2[c], period[c]);
                    end
                end else if (period[c] != '1) begin
                    period[c] <= period[c] + COUNTER_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state    <= S_IDLE;
            dump_idx <= '0;
        end else begin
            state    <= state_next;
            dump_idx <= dump_idx_next;
        end
    end

    assign ch_sel = dump_idx[CH_W:1];

    always_comb begin
        state_next         = state;
        dump_idx_next      = dump_idx;
        register_operation = 2'd0;
        register_number    = 8'd0;
        register_write     = 32'd0;
        busy               = 1'b0;
        irq                = 1'b0;
        case (state)
            S_IDLE: begin
                if (start)
                    state_next = S_RUN;
            end
            S_RUN: begin
                if (stop) begin
                    state_next    = S_DUMP;
                    dump_idx_next = '0;
                end
            end
            S_DUMP: begin
                busy               = 1'b1;
                register_operation = 2'd2;
                register_number    = 8'(dump_idx) + 8'd1;
                register_write     = dump_idx[0] ? 32'(f2[ch_sel]) : 32'(f1[ch_sel]);
                if (register_ack) begin
                    if (dump_idx == LAST_REG)
                        state_next = S_DONE;
                    else
                        dump_idx_next = dump_idx + (CH_W + 1)'(1);
                end
            end
            S_DONE: begin
                busy       = 1'b1;
                irq        = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_multi_pixel_frequency_manager.sv
// tb/tb_multi_pixel_frequency_manager.sv - self-checking bench for multi_pixel_frequency_manager

module tb_multi_pixel_frequency_manager;

    localparam int CH   = 3;
    localparam int PW   = 4;
    localparam int DW   = 8;
    localparam int CW   = 32;
    localparam int NREG = 2 * CH;
    // Windows from CLOCK=1000, F1=100, F2=50, DEV=10.
    localparam longint W1_MIN = 9;
    localparam longint W1_MAX = 11;
    localparam longint W2_MIN = 18;
    localparam longint W2_MAX = 22;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [DW-1:0]   data = '0;
    logic [DW-1:0]   threshold = '0;
    logic            data_valid = 1'b0;
    logic            line_start = 1'b0;
    logic [CH*PW-1:0] pixel_indexes = '0;
    logic            start = 1'b0;
    logic            stop = 1'b0;
    logic            clear = 1'b0;
    logic            register_ack = 1'b1;
    logic [1:0]      register_operation;
    logic [7:0]      register_number;
    logic [31:0]     register_write;
    logic            busy;
    logic            irq;

    always #5 clk = ~clk;

    multi_pixel_frequency_manager #(
        .CHANNELS(CH), .PIXEL_INDEX_WIDTH(PW), .DATA_WIDTH(DW), .COUNTER_WIDTH(CW),
        .CLOCK(1000), .FREQUENCY_1(100), .FREQUENCY_2(50), .FREQUENCY_DEVIATION(10)
    ) dut (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
        .data(data), .data_valid(data_valid), .line_start(line_start),
        .pixel_indexes(pixel_indexes), .threshold(threshold),
        .start(start), .stop(stop), .clear(clear),
        .register_operation(register_operation), .register_number(register_number),
        .register_write(register_write), .register_ack(register_ack),
        .busy(busy), .irq(irq)
    );

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    // Reference model: phase, dump position, and per-channel edge timestamps
    // measured in RUN cycles; a period is the distance between two edges.
    int     m_state;   // 0 idle, 1 run, 2 dump, 3 done
    int     m_k;
    int     m_cnt;
    longint m_rt;
    bit     m_smp   [CH];
    bit     m_prv   [CH];
    bit     m_armed [CH];
    longint m_last  [CH];
    longint m_f1    [CH];
    longint m_f2    [CH];

    task automatic m_clear();
        m_cnt = 0;
        for (int c = 0; c < CH; c++) begin
            m_smp[c] = 0; m_prv[c] = 0; m_armed[c] = 0;
            m_last[c] = 0; m_f1[c] = 0; m_f2[c] = 0;
        end
    endtask

    function automatic longint sat32(input longint v);
        return (v > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v;
    endfunction

    task automatic m_run_cycle();
        int cur;
        m_rt++;
        for (int c = 0; c < CH; c++) begin
            if (m_smp[c] && !m_prv[c]) begin
                if (m_armed[c]) begin
                    longint p;
                    p = m_rt - m_last[c];
                    if (p >= W1_MIN && p <= W1_MAX)      m_f1[c] = sat32(m_f1[c] + p);
                    else if (p >= W2_MIN && p <= W2_MAX) m_f2[c] = sat32(m_f2[c] + p);
                end
                m_armed[c] = 1;
                m_last[c]  = m_rt;
            end
            m_prv[c] = m_smp[c];
        end
        if (data_valid) begin
            cur = line_start ? 0 : m_cnt;
            for (int c = 0; c < CH; c++)
                if (cur == int'(pixel_indexes[c*PW +: PW])) m_smp[c] = data[DW-1];
            m_cnt = line_start ? 1 : (m_cnt + 1) % (1 << PW);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0; m_k = 0; m_rt = 0;
            m_clear();
        end else begin
            case (m_state)
                0: begin
                    if (clear) m_clear();
                    if (start) m_state = 1;
                end
                1: begin
                    if (clear) m_clear();
                    else m_run_cycle();
                    if (stop) begin m_state = 2; m_k = 0; end
                end
                2: if (register_ack) begin
                    if (m_k == NREG - 1) m_state = 3;
                    else m_k++;
                end
                default: m_state = 0;
            endcase
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        longint ew;
        ew = 0;
        if (m_state == 2) ew = (m_k % 2 == 0) ? m_f1[m_k/2] : m_f2[m_k/2];
        chk("op",     register_operation, (m_state == 2) ? 2 : 0);
        chk("number", register_number,    (m_state == 2) ? m_k + 1 : 0);
        chk("write",  register_write,     ew);
        chk("busy",   busy,               (m_state >= 2) ? 1 : 0);
        chk("irq",    irq,                (m_state == 3) ? 1 : 0);
    endtask

    task automatic tick();
        @(negedge clk);
        if (cmp_en) compare_model();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_and_start();
        data_valid = 0; line_start = 0;
        clear = 1; tick(); clear = 0;
        start = 1; tick(); start = 0;
    endtask

    // Drive the bit through pixel 0 every cycle: lo cycles low, then hi cycles high.
    task automatic pulses(input int lo, input int hi, input int n);
        for (int r = 0; r < n; r++) begin
            for (int i = 0; i < lo; i++) begin
                data_valid = 1; line_start = 1; data = 8'h00; tick();
            end
            for (int i = 0; i < hi; i++) begin
                data_valid = 1; line_start = 1; data = 8'h80; tick();
            end
        end
    endtask

    longint d_got [NREG];
    int d_irq_cnt, d_irq_at, d_last6_at, d_hold_seen, d_first_at, d_regs_seen;

    task automatic dump_run(input int hold_reg, input int hold_n, input int reset_reg);
        int held;
        held = 0;
        for (int i = 0; i < NREG; i++) d_got[i] = -1;
        d_irq_cnt = 0; d_irq_at = -1; d_last6_at = -1;
        d_hold_seen = 0; d_first_at = -1; d_regs_seen = 0;
        data_valid = 0; line_start = 0; register_ack = 1;
        stop = 1; tick(); stop = 0;
        for (int i = 0; i < 40; i++) begin
            if (irq) begin d_irq_cnt++; d_irq_at = i; end
            if (register_operation == 2'd2) begin
                if (d_first_at < 0) d_first_at = i;
                if (register_number >= 1 && register_number <= NREG) begin
                    if (d_got[register_number-1] < 0) d_regs_seen++;
                    d_got[register_number-1] = register_write;
                end
                if (register_number == NREG) d_last6_at = i;
                if (register_number == reset_reg) begin
                    rst_n = 0;
                    #1;
                    chk("rst_op",     register_operation, 0);
                    chk("rst_number", register_number,    0);
                    chk("rst_write",  register_write,     0);
                    chk("rst_busy",   busy,               0);
                    chk("rst_irq",    irq,                0);
                    tick(); tick();
                    rst_n = 1;
                    register_ack = 1;
                    return;
                end
                if (register_number == hold_reg) d_hold_seen++;
                if (register_number == hold_reg && held < hold_n) begin
                    register_ack = 0; held++;
                end else begin
                    register_ack = 1;
                end
            end else begin
                register_ack = 1;
            end
            if (i > 0 && !busy && register_operation == 2'd0) break;
            tick();
        end
        register_ack = 1;
    endtask

    initial begin
        int hp;
        bit idx_small;
        bit bitv;
        int irq_after;
        int busy_seen;

        rst_n = 0;
        repeat (3) tick();
        rst_n = 1;
        chk("reset_op",     register_operation, 0);
        chk("reset_number", register_number,    0);
        chk("reset_write",  register_write,     0);
        chk("reset_busy",   busy,               0);
        chk("reset_irq",    irq,                0);
        cmp_en = 1;

        // Channel 0 square wave, period 10, four edges.
        pixel_indexes = 12'hFF0;
        clear_and_start();
        pulses(5, 5, 4);
        dump_run(0, 0, 0);
        chk("s1_first_latency", d_first_at, 0);
        chk("s1_reg1", d_got[0], 30);
        chk("s1_reg2", d_got[1], 0);
        chk("s1_regs", d_regs_seen, NREG);
        chk("s1_irq_count", d_irq_cnt, 1);
        chk("s1_irq_timing", d_irq_at, d_last6_at + 1);

        // Channel 1: spacings 20, 20, 15.
        pixel_indexes = 12'hF0F;
        clear_and_start();
        pulses(10, 10, 3);
        pulses(5, 3, 1);
        pulses(3, 0, 1);
        dump_run(0, 0, 0);
        chk("s2_reg3_f1", d_got[2], 0);
        chk("s2_reg4_f2", d_got[3], 40);
        chk("s2_reg1", d_got[0], 0);

        // Indexes {0,5,5}: pixel 5 MSB high.
        pixel_indexes = 12'h550;
        clear_and_start();
        data_valid = 1; line_start = 1; data = 8'h00; tick();
        line_start = 0;
        for (int p = 1; p < 5; p++) tick();
        chk("s3_sample1_before", dut.sample[1], 0);
        data = 8'h80; tick();
        chk("s3_sample1", dut.sample[1], 1);
        chk("s3_sample2", dut.sample[2], 1);
        chk("s3_sample0", dut.sample[0], 0);
        data_valid = 0; data = 8'h00;
        dump_run(0, 0, 0);

        // Ack stalled three cycles on register 2.
        pixel_indexes = 12'hFF0;
        clear_and_start();
        pulses(5, 5, 3);
        dump_run(2, 3, 0);
        chk("s4_hold_cycles", d_hold_seen, 4);
        chk("s4_reg1", d_got[0], 20);
        chk("s4_irq_count", d_irq_cnt, 1);
        chk("s4_irq_timing", d_irq_at, d_last6_at + 1);

        // Reset during register 3.
        pulses(0, 0, 0);
        start = 1; tick(); start = 0;
        pulses(5, 5, 3);
        dump_run(0, 0, 3);
        irq_after = 0; busy_seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (irq) irq_after++;
            if (busy) busy_seen++;
            tick();
        end
        chk("s5_no_irq", irq_after, 0);
        chk("s5_idle_busy", busy_seen, 0);
        start = 1; tick(); start = 0;
        dump_run(0, 0, 0);
        chk("s5_zero_sum", d_got[0] + d_got[1] + d_got[2] + d_got[3] + d_got[4] + d_got[5], 0);
        chk("s5_regs", d_regs_seen, NREG);

        // start and stop together in IDLE.
        start = 1; stop = 1; tick(); start = 0; stop = 0;
        busy_seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (busy) busy_seen++;
            tick();
        end
        chk("s6_busy_low", busy_seen, 0);
        dump_run(0, 0, 0);
        chk("s6_regs", d_regs_seen, NREG);
        chk("s6_irq_count", d_irq_cnt, 1);

        // Randomized traffic against the model.
        hp = 5; idx_small = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 200 == 0) hp = $urandom_range(3, 12);
            if (cyc % 500 == 0) begin
                idx_small = 1'($urandom % 2);
                for (int c = 0; c < CH; c++)
                    pixel_indexes[c*PW +: PW] = idx_small ? PW'($urandom_range(0, 2)) : PW'($urandom);
            end
            data_valid   = ($urandom % 10) != 0;
            line_start   = idx_small ? (($urandom % 3) == 0) : (($urandom % 12) == 0);
            bitv         = 1'((cyc / hp) % 2) ^ (($urandom % 40) == 0);
            data         = {bitv, 7'($urandom)};
            threshold    = DW'($urandom);
            start        = ($urandom % 15) == 0;
            stop         = ($urandom % 120) == 0;
            clear        = ($urandom % 500) == 0;
            register_ack = ($urandom % 4) != 0;
            tick();
        end
        start = 0; stop = 0; clear = 0; data_valid = 0; line_start = 0; register_ack = 1;
        repeat (20) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multi_pixel_frequency_manager.md
# multi_pixel_frequency_manager

Parametrised successor to the three-pixel frequency analyzer manager. It samples CHANNELS configurable pixel positions from the line-scan pixel stream and measures the period between rising edges of each sampled bit. Each period is classified into one of two frequency windows, and the time spent in each window is accumulated per channel. On `stop` it dumps 2*CHANNELS result registers through the `axi_slave_impl` register port with a write-acknowledge handshake, then raises `irq`.

## Interface
Parameters:
- CHANNELS, 3: number of sampled pixels (1..16).
- PIXEL_INDEX_WIDTH, 10: width of the pixel-in-line counter and of each index.
- DATA_WIDTH, 8: pixel data width.
- COUNTER_WIDTH, 32: width of period counters and accumulators (≤32).
- CLOCK, 100000000: clock frequency in Hz.
- FREQUENCY_1, 9000: first frequency in Hz.
- FREQUENCY_2, 11000: second frequency in Hz.
- FREQUENCY_DEVIATION, 10: window half-width, in percent of the nominal period.

Ports:
- s00_axi_aclk  in  1  sole clock. All logic is rising-edge.
- s00_axi_aresetn  in  1  asynchronous, active-low reset.
- data  in  DATA_WIDTH  pixel value.
- data_valid  in  1  `data` is valid this cycle.
- line_start  in  1  with `data_valid`, marks pixel index 0 of a line.
- pixel_indexes  in  CHANNELS*PIXEL_INDEX_WIDTH  packed index per channel; channel c occupies bits [c*W +: W].
- threshold  in  DATA_WIDTH  sample threshold (used only with the macro).
- start, stop, clear  in  1  each active-high, sampled synchronously.
- register_operation  out  2  2 = write, 0 = none.
- register_number  out  8  target register, 1-based.
- register_write  out  32  write data, zero-extended from COUNTER_WIDTH.
- register_ack  in  1  slave has accepted the current write.
- busy  out  1  high in DUMP and DONE.
- irq  out  1  one-cycle pulse at the end of a dump.

## Operation
Window limits are elaboration-time localparams, with P1 = CLOCK/FREQUENCY_1 and P2 = CLOCK/FREQUENCY_2:
- Pn_MIN = Pn - Pn*DEV/100.
- Pn_MAX = Pn + Pn*DEV/100.
- All integer division.

States and transitions:
- IDLE: `start` → RUN. `start` and `stop` together → RUN; `stop` is ignored.
- RUN: `stop` → DUMP. `start` is ignored.
- DUMP: advances to DONE after the final ack.
- DONE: one cycle, then → IDLE.

Pixel capture (RUN only):
- Pixel counter: each `data_valid` increments it, wrapping at 2^PIXEL_INDEX_WIDTH. `line_start` with `data_valid` loads 1, meaning the current pixel is index 0.
- The current pixel index is 0 on `line_start`, otherwise the counter value.
- When the current index equals the index for channel c, `sample[c]` ← `data[DATA_WIDTH-1]`.
- Several channels with equal indexes all capture the same pixel.

Per-channel measurement (RUN only):
- `period[c]` increments every cycle and saturates at all-ones.
- On a rising edge of `sample[c]` (registered previous value 0, current value 1):
  - First edge after clear or reset: arms the channel only.
  - Later edges, with P = `period[c]`:
    - P1_MIN ≤ P ≤ P1_MAX: `f1[c]` += P.
    - Otherwise, if P2_MIN ≤ P ≤ P2_MAX: `f2[c]` += P.
    - Otherwise: discarded.
  - On every rising edge, `period[c]` ← 1.
- Accumulators saturate at all-ones.
- When the windows overlap, F1 wins.

Clear behaviour:
- In IDLE or RUN, `clear` zeroes `sample`, `period`, the armed flags, `f1`, `f2` and the pixel counter. The state is unchanged.
- `clear` is ignored in DUMP and DONE.

DUMP sequence:
- k = 0..2*CHANNELS-1 presents `register_operation` = 2 and `register_number` = k+1.
- `register_write` = `f1[k/2]` for even k, `f2[k/2]` for odd k.
- Outputs are held stable until `register_ack` is sampled high.
- Accumulators are frozen during DUMP and keep their values after it.

Reset: asynchronous and total.
- State returns to IDLE. All counters, accumulators and flags are zeroed.
- Outputs go to 0: `register_operation`, `register_number`, `register_write`, `busy`, `irq`.
- Reset mid-dump abandons the dump; no `irq` is produced.

## Timing
- Capture: `sample[c]` updates 1 cycle after the matching `data_valid`.
- Edge detect and accumulate: 1 further cycle. The accumulator is visible 2 cycles after the sampling edge.
- DUMP entry: the first write is presented in the cycle after `stop` is sampled in RUN.
- Handshake: ack sampled in cycle t → the next write is presented in t+1. With ack tied high, one register per cycle; a dump takes 2*CHANNELS cycles.
- `irq` is high for exactly the one DONE cycle, the cycle after the final ack.
- `busy` falls with the return to IDLE.
- Outside DUMP, `register_operation`, `register_number` and `register_write` are 0.

## Configuration
FREQ_ANALYZER_THRESHOLD_EN:
- Defined: the sampled bit is (`data` ≥ `threshold`), an unsigned compare.
- Undefined: the sampled bit is `data[DATA_WIDTH-1]`. The `threshold` port is present but unused.

## Test plan
Bench parameters: CLOCK=1000, FREQUENCY_1=100, FREQUENCY_2=50, DEV=10, which gives windows 9..11 and 18..22. Ack tied high except in scenario 4.
- Channel 0 square wave, toggling every 5 cycles, 4 edges → `f1[0]`=30, `f2[0]`=0. Dump writes 30 to register 1, then 0 to register 2.
- Channel 1 with rising-edge period 20 ×3 edges, followed by one edge with period 15 → `f2[1]`=40; the 15-cycle period is discarded.
- `line_start` and index match: indexes {0,5,5}, with pixel 5 MSB high → `sample[1]` and `sample[2]` both go to 1 one cycle after pixel 5.
- Dump with `register_ack` low for 3 cycles on register 2 → register 2 is held for 4 cycles. `irq` pulses once, the cycle after the 6th ack.
- `s00_axi_aresetn` low during the write of register 3 → outputs read 0 immediately, no `irq`, state IDLE, and a subsequent dump writes all zeros.
- `start` and `stop` in the same IDLE cycle → RUN entered, `busy` stays 0. A later `stop` → dump of 6 registers.
